// File: rtl/io_pkg.sv
// Shared constants for the LCR580 port I/O hub: port numbers, status-byte
// bit positions and a small saturation helper for the status count nibble.
package io_pkg;

  typedef logic [7:0] port_t;

  localparam port_t PORT_KDATA    = 8'h00;
  localparam port_t PORT_KSTAT    = 8'h01;
  localparam port_t PORT_CTRL     = 8'h02;
  localparam port_t PORT_GPO_BASE = 8'h10;
  localparam port_t PORT_BORDER   = 8'hFE;

  // Bit positions inside the keyboard status byte (port 0x01)
  localparam int ST_NEMPTY = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_OVF    = 2;
  localparam int ST_TICK   = 3;

  // Clamp a count to what fits in the status nibble
  function automatic logic [3:0] sat_nibble(input int unsigned v);
    return (v > 15) ? 4'hF : v[3:0];
  endfunction

endpackage

// File: rtl/io_hub_if.sv
// CPU port bus seen by the I/O hub: address, write data, the two strobes
// and the combinational read-data return path.
interface io_hub_if;
  logic [15:0] address;
  logic [7:0]  out;
  logic        port_we;
  logic        port_rd;
  logic [7:0]  pin;

  modport master (output address, out, port_we, port_rd, input pin);
  modport slave  (input address, out, port_we, port_rd, output pin);
endinterface

// File: rtl/io_fifo.sv
// Generic synchronous FIFO with first-word-fall-through head output.
// A pop and a push in the same cycle are both honoured, including when full.
module io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Data storage write port
  // NOTE: storage has no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/io_hub.sv
// LCR580 port I/O hub: keyboard FIFO, border register, general output
// latches and (with IO_HUB_TIMER_EN defined) a frame timer raising irq.
module io_hub
  import io_pkg::*;
#(
  parameter int KBD_DEPTH = 16,
  parameter int NUM_OUT   = 4,
  parameter int TIMER_DIV = 500000
) (
  input  logic                   clock,
  input  logic                   reset_n,
  io_hub_if.slave                bus,
  input  logic                   kdone,
  input  logic [7:0]             kdata,
  input  logic                   iff1,
  output logic [2:0]             border,
  output logic [8*NUM_OUT-1:0]   gpo,
  output logic                   irq
);
  localparam int CW = $clog2(KBD_DEPTH) + 1;

  port_t                   port, side_port;
  logic                    we_q, rd_q, wr_commit, rd_fall;
  logic                    pop, ovf_q, ovf_set, ovf_clr;
  logic                    full, empty;
  logic [CW-1:0]           count;
  logic [7:0]              head, stat;
  logic [NUM_OUT-1:0][7:0] gpo_q;
  logic                    ten_q, tick_q;
  logic                    unused_addr;

  assign port        = bus.address[7:0];
  assign unused_addr = ^bus.address[15:8];
  assign wr_commit   = bus.port_we & ~we_q;
  assign rd_fall     = rd_q & ~bus.port_rd;
  assign pop         = rd_fall && (side_port == PORT_KDATA);
  assign ovf_clr     = rd_fall && (side_port == PORT_KSTAT);
  // A same-cycle pop frees the slot, so a full FIFO only drops when not popping
  assign ovf_set     = kdone & full & ~pop;
  assign gpo         = gpo_q;

  // Strobe history and the port number held while a read is in progress
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      we_q      <= 1'b0;
      rd_q      <= 1'b0;
      side_port <= '0;
    end else begin
      we_q <= bus.port_we;
      rd_q <= bus.port_rd;
      if (bus.port_rd) side_port <= port;
    end
  end

  io_fifo #(.WIDTH(8), .DEPTH(KBD_DEPTH)) u_kbd_fifo (
    .clk   (clock),
    .rst_n (reset_n),
    .push  (kdone),
    .din   (kdata),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );

  // Sticky keyboard overflow; a new drop beats a coincident status-read clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     ovf_q <= 1'b0;
    else if (ovf_set) ovf_q <= 1'b1;
    else if (ovf_clr) ovf_q <= 1'b0;
  end

  // Border and general output latches, committed once per write strobe
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      border <= '0;
      gpo_q  <= '0;
    end else if (wr_commit) begin
      if (port == PORT_BORDER) border <= bus.out[2:0];
      for (int k = 0; k < NUM_OUT; k++) begin
        if (port == 8'(int'(PORT_GPO_BASE) + k)) gpo_q[k] <= bus.out;
      end
    end
  end

`ifdef IO_HUB_TIMER_EN
  localparam int TW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  logic [TW-1:0] tcnt;
  logic          wrap, ctrl_wr;

  assign ctrl_wr = wr_commit && (port == PORT_CTRL);
  assign wrap    = ten_q && (tcnt == TW'(TIMER_DIV - 1));

  // Frame timer, control register and registered interrupt request
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tcnt   <= '0;
      ten_q  <= 1'b0;
      tick_q <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (ctrl_wr) ten_q <= bus.out[0];
      if (!ten_q || wrap) tcnt <= '0;
      else                tcnt <= tcnt + 1'b1;
      if (wrap)                        tick_q <= 1'b1;
      else if (ctrl_wr && bus.out[1])  tick_q <= 1'b0;
      irq <= tick_q & ten_q & iff1;
    end
  end
`else
  logic unused_iff1;
  assign unused_iff1 = iff1;
  assign ten_q       = 1'b0;
  assign tick_q      = 1'b0;
  assign irq         = 1'b0;
`endif

  // Combinational read mux
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    stat            = '0;
    stat[ST_NEMPTY] = ~empty;
    stat[ST_FULL]   = full;
    stat[ST_OVF]    = ovf_q;
    stat[ST_TICK]   = tick_q;
    stat[7:4]       = sat_nibble(32'(count));
    bus.pin         = '0;
    case (port)
      PORT_KDATA: bus.pin = empty ? 8'h00 : head;
      PORT_KSTAT: bus.pin = stat;
      PORT_CTRL:  bus.pin = {6'b0, tick_q, ten_q};
      default: begin
        for (int k = 0; k < NUM_OUT; k++) begin
          if (port == 8'(int'(PORT_GPO_BASE) + k)) bus.pin = gpo_q[k];
        end
      end
    endcase
  end
endmodule

// File: tb/tb_io_hub.sv
// Self-checking bench for io_hub: directed scenarios plus random traffic
// compared with a queue-based reference model. Timer checks adapt to
// whether IO_HUB_TIMER_EN is defined.
module tb_io_hub;
  localparam int KD   = 16;
  localparam int NO   = 4;
  localparam int TDIV = 10;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              kdone, iff1;
  logic [7:0]        kdata;
  logic [2:0]        border;
  logic [8*NO-1:0]   gpo;
  logic              irq;

  io_hub_if bus();

  io_hub #(.KBD_DEPTH(KD), .NUM_OUT(NO), .TIMER_DIV(TDIV)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .kdone   (kdone),
    .kdata   (kdata),
    .iff1    (iff1),
    .border  (border),
    .gpo     (gpo),
    .irq     (irq)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0]         q[$];
  logic               ovf_m;
  logic [2:0]         border_m;
  logic [NO-1:0][7:0] gpo_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_status();
    logic [7:0] s;
    int n;
    n    = q.size();
    s    = '0;
    s[7:4] = (n > 15) ? 4'hF : 4'(n);
    s[2] = ovf_m;
    s[1] = (n == KD);
    s[0] = (n != 0);
    return s;
  endfunction

  function automatic logic [7:0] exp_read(input logic [7:0] p);
    if (p == 8'h00) return (q.size() != 0) ? q[0] : 8'h00;
    if (p == 8'h01) return exp_status();
    if (p >= 8'h10 && p < 8'h10 + NO) return gpo_m[p - 8'h10];
    return 8'h00;
  endfunction

  function automatic void model_reset();
    q.delete();
    ovf_m    = 1'b0;
    border_m = '0;
    gpo_m    = '0;
  endfunction

  function automatic void model_push(input logic [7:0] b);
    if (q.size() < KD) q.push_back(b);
    else               ovf_m = 1'b1;
  endfunction

  // Port write; data changes while the strobe is held so a repeated commit shows
  task automatic wr(input logic [7:0] p, input logic [7:0] d, input int hold);
    bus.address = {8'(($urandom_range(0, 255))), p};
    bus.out     = d;
    bus.port_we = 1'b1;
    @(negedge clock);
    bus.out = ~d;
    for (int i = 1; i < hold; i++) @(negedge clock);
    bus.port_we = 1'b0;
    @(negedge clock);
    if (p == 8'hFE) border_m = d[2:0];
    if (p >= 8'h10 && p < 8'h10 + NO) gpo_m[p - 8'h10] = d;
  endtask

  // Port read: check data, then release the strobe on a different address
  task automatic rd(input logic [7:0] p, input string tag, output logic [7:0] v);
    logic [7:0] e;
    e = exp_read(p);
    bus.address = {8'(($urandom_range(0, 255))), p};
    bus.port_rd = 1'b1;
    #1 v = bus.pin;
    check(tag, v, e);
    repeat ($urandom_range(1, 3)) @(negedge clock);
    bus.port_rd = 1'b0;
    bus.address = 16'h00FF;
    @(negedge clock);
    if (p == 8'h00 && q.size() != 0) void'(q.pop_front());
    if (p == 8'h01) ovf_m = 1'b0;
  endtask

  // Pop the keyboard FIFO with a push landing in the very same cycle
  task automatic rd_push(input logic [7:0] b, output logic [7:0] v);
    bus.address = 16'h0000;
    bus.port_rd = 1'b1;
    #1 v = bus.pin;
    check("rdpush_head", v, exp_read(8'h00));
    @(negedge clock);
    bus.port_rd = 1'b0;
    kdone = 1'b1;
    kdata = b;
    @(negedge clock);
    kdone = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    model_push(b);
  endtask

  task automatic kpush(input logic [7:0] b);
    kdone = 1'b1;
    kdata = b;
    @(negedge clock);
    kdone = 1'b0;
    model_push(b);
  endtask

  task automatic peek(input logic [7:0] p, output logic [7:0] v);
    bus.address = {8'h00, p};
    #1 v = bus.pin;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v, first, last_b;
    int op;

    reset_n = 1'b0;
    kdone = 1'b0; kdata = '0; iff1 = 1'b0;
    bus.address = '0; bus.out = '0; bus.port_we = 1'b0; bus.port_rd = 1'b0;
    model_reset();
    #12 reset_n = 1'b1;
    @(negedge clock);

    // Reset state
    check("rst_border", 32'(border), 32'h0);
    check("rst_gpo", 32'(gpo), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    peek(8'h01, v); check("rst_stat", 32'(v), 32'h00);

    // Border write, strobe held for 3 cycles
    wr(8'hFE, 8'h05, 3);
    check("border_held", 32'(border), 32'h5);

    // Two keys then drain
    kpush(8'h1C);
    kpush(8'h32);
    rd(8'h01, "stat_two", v);  check("stat_two_c", 32'(v), 32'h21);
    rd(8'h00, "pop_1c", v);    check("pop_1c_c", 32'(v), 32'h1C);
    rd(8'h00, "pop_32", v);    check("pop_32_c", 32'(v), 32'h32);
    rd(8'h00, "pop_empty", v); check("pop_empty_c", 32'(v), 32'h00);
    peek(8'h01, v);            check("stat_empty", 32'(v), 32'h00);

    // Overflow: seventeen pushes into a 16-deep FIFO
    for (int i = 0; i < KD + 1; i++) kpush(8'($urandom_range(0, 255)));
    rd(8'h01, "stat_ovf", v);  check("stat_ovf_c", 32'(v), 32'hF7);
    rd(8'h01, "stat_clr", v);  check("stat_clr_c", 32'(v), 32'hF3);

    // Full FIFO: pop and push in the same cycle
    first  = q[0];
    last_b = 8'($urandom_range(0, 255));
    rd_push(last_b, v);
    check("rdpush_first", 32'(v), 32'(first));
    peek(8'h01, v); check("rdpush_stat", 32'(v), 32'hF3);
    @(negedge clock);
    for (int i = 0; i < KD; i++) rd(8'h00, "drain", v);
    check("drain_last", 32'(v), 32'(last_b));

    // General output latches
    wr(8'h13, 8'hA5, 2);
    check("gpo3_bus", 32'(gpo[31:24]), 32'hA5);
    peek(8'h13, v); check("gpo3_rd", 32'(v), 32'hA5);
    wr(8'h14, 8'h5A, 1);
    peek(8'h14, v); check("gpo4_rd", 32'(v), 32'h00);
    check("gpo_vec", 32'(gpo), 32'(gpo_m));

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2, 3: kpush(8'($urandom_range(0, 255)));
        4: rd(8'h00, "rnd_pop", v);
        5: rd(8'h01, "rnd_stat", v);
        6: begin
          wr(8'h10 + 8'($urandom_range(0, NO)), 8'($urandom_range(0, 255)),
             $urandom_range(1, 3));
          check("rnd_gpo", 32'(gpo), 32'(gpo_m));
        end
        7: begin
          wr(8'hFE, 8'($urandom_range(0, 255)), $urandom_range(1, 2));
          check("rnd_border", 32'(border), 32'(border_m));
        end
        default: begin
          op = $urandom_range(0, 255);
          peek(8'(op), v);
          check("rnd_peek", 32'(v), 32'(exp_read(8'(op))));
          @(negedge clock);
        end
      endcase
    end

`ifdef IO_HUB_TIMER_EN
    // Timer: enable, tick after TDIV cycles, irq one cycle later
    iff1 = 1'b1;
    bus.address = 16'h0002; bus.out = 8'h01; bus.port_we = 1'b1;
    @(negedge clock);
    bus.port_we = 1'b0;
    repeat (TDIV - 1) @(negedge clock);
    peek(8'h02, v); check("tmr_before", 32'(v), 32'h01);
    check("irq_before", 32'(irq), 32'h0);
    @(negedge clock);
    peek(8'h02, v); check("tmr_tick", 32'(v), 32'h03);
    peek(8'h01, v); check("stat_tick", 32'(v[3]), 32'h1);
    check("irq_lat", 32'(irq), 32'h0);
    @(negedge clock);
    check("irq_up", 32'(irq), 32'h1);
    // Acknowledge
    bus.address = 16'h0002; bus.out = 8'h03; bus.port_we = 1'b1;
    @(negedge clock);
    bus.port_we = 1'b0;
    peek(8'h02, v); check("tmr_ack", 32'(v), 32'h01);
    check("irq_hold", 32'(irq), 32'h1);
    @(negedge clock);
    check("irq_down", 32'(irq), 32'h0);
    // Next tick with interrupts masked by iff1
    iff1 = 1'b0;
    repeat (TDIV - 2) @(negedge clock);
    peek(8'h02, v); check("tmr_tick2", 32'(v), 32'h03);
    check("irq_masked", 32'(irq), 32'h0);
    iff1 = 1'b1;
    @(negedge clock);
    check("irq_unmask", 32'(irq), 32'h1);
    // Disable keeps pending but drops irq; then clear and stay idle
    wr(8'h02, 8'h00, 1);
    peek(8'h02, v); check("tmr_dis", 32'(v), 32'h02);
    check("irq_dis", 32'(irq), 32'h0);
    wr(8'h02, 8'h02, 1);
    repeat (3 * TDIV) @(negedge clock);
    peek(8'h02, v); check("tmr_idle", 32'(v), 32'h00);
    check("irq_idle", 32'(irq), 32'h0);
`else
    // Timer not built: control port inert, no interrupt ever
    iff1 = 1'b1;
    wr(8'h02, 8'h03, 1);
    repeat (3 * TDIV) @(negedge clock);
    peek(8'h02, v); check("ctrl_absent", 32'(v), 32'h00);
    peek(8'h01, v); check("stat_notick", 32'(v), 32'(exp_status()));
    check("irq_absent", 32'(irq), 32'h0);
`endif

    // Reset in the middle of activity
    for (int i = 0; i < KD + 2; i++) kpush(8'($urandom_range(0, 255)));
    wr(8'h11, 8'h77, 1);
    #3 reset_n = 1'b0;
    #10 reset_n = 1'b1;
    model_reset();
    @(negedge clock);
    peek(8'h01, v); check("mrst_stat", 32'(v), 32'h00);
    peek(8'h00, v); check("mrst_head", 32'(v), 32'h00);
    check("mrst_gpo", 32'(gpo), 32'h0);
    check("mrst_border", 32'(border), 32'h0);
    kpush(8'h42);
    rd(8'h00, "mrst_pop", v); check("mrst_pop_c", 32'(v), 32'h42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/io_hub.md
Name: io_hub

Overview:
- Parametrised next-generation port I/O block for the LCR580 (8080-compatible) system.
- Sits between the CPU port bus (address/out/port_we/port_rd/pin) and the peripherals.
- Adds three things to the existing single-register port decoder:
  - a buffered keyboard FIFO with overflow tracking;
  - NUM_OUT general-purpose output latches;
  - an optional frame timer that raises an interrupt request.

Parameters:
KBD_DEPTH, 16, keyboard FIFO depth in bytes; power of two, 2..256
NUM_OUT, 4, number of 8-bit general output latches, 1..16
TIMER_DIV, 500000, clock cycles per timer tick (25 MHz / 50 Hz)

Ports:
clock  in  1  system clock (25 MHz domain, same as CPU)
reset_n  in  1  asynchronous active-low reset
address  in  16  CPU address bus; port number is address[7:0]
out  in  8  CPU write data
port_we  in  1  port write strobe, level for one or more cycles
port_rd  in  1  port read strobe, level for one or more cycles
pin  out  8  port read data to CPU, combinational from address[7:0] and registered state
kdone  in  1  keyboard byte-valid pulse, one cycle
kdata  in  8  keyboard byte, valid when kdone=1
iff1  in  1  CPU interrupt-enable flag
border  out  3  border colour to vga
gpo  out  8*NUM_OUT  output latches; latch k is at gpo[8k+7:8k]
irq  out  1  interrupt request, level

Behaviour:
- Reset is asynchronous on negedge reset_n. Reset values:
  - border=0, gpo=0, irq=0;
  - FIFO empty, count=0, overflow=0;
  - timer counter=0, tick pending=0, timer enable=0.
- Write strobe detection:
  - Writes commit once per strobe, on the first cycle port_we is high. Use a registered previous-value edge detector.
  - A held strobe writes exactly once.
- Write map (port = address[7:0]):
  - 0xFE: border <= out[2:0].
  - 0x02: control register.
    - bit0 = timer enable.
    - bit1 = 1 clears tick pending (write-one-to-clear).
  - 0x10..0x10+NUM_OUT-1: gpo latch (port-0x10) <= out.
  - All other ports are ignored.
- Read map (pin is combinational; 0x00 for unmapped ports):
  - 0x00: FIFO head byte, or 0x00 when empty.
  - 0x01: status byte.
    - bit0 = not empty; bit1 = full; bit2 = overflow; bit3 = tick pending.
    - bits7:4 = min(count, 15).
  - 0x02: {6'b0, tick pending, timer enable}.
  - 0x10..: gpo latch readback.
- Read side effects occur on the falling edge of port_rd (registered), so data stays stable for the whole read:
  - Port 0x00: pop one entry if non-empty. Popping an empty FIFO changes nothing.
  - Port 0x01: clear overflow.
  - The port number used for the side effect is the value latched while port_rd was high.
- FIFO push:
  - kdone=1 and not full: write kdata at the write pointer, which advances modulo KBD_DEPTH.
  - kdone=1 and full: byte dropped, overflow <= 1 (sticky).
- Push and pop in the same cycle:
  - Both occur and count is unchanged.
  - If the FIFO is full, the pop frees the slot and the push is accepted with no overflow.
- If an overflow set and a status-read clear coincide, set wins.
- count width is log2(KBD_DEPTH)+1 bits; full means count==KBD_DEPTH.
- Timer, with enable=1:
  - counter increments each clock; at TIMER_DIV-1 it wraps to 0 and sets tick pending.
  - enable=0 holds the counter at 0.
  - If an ack write and a wrap coincide, the wrap wins and pending stays 1.
- irq = tick pending & timer enable & iff1, registered with one cycle of latency.
- A reset mid-operation discards FIFO contents and any half-seen strobes.

Optional Feature:
- Macro: IO_HUB_TIMER_EN.
- Defined: the timer, control register 0x02, status bit3 and irq behave as described above.
- Undefined:
  - no timer logic is built;
  - irq tied to 0;
  - port 0x02 reads 0x00 and writes to it are ignored;
  - status bit3 = 0.

Decomposition:
- Shared package (io_pkg) holds:
  - port-number constants: PORT_KDATA=0x00, PORT_KSTAT=0x01, PORT_CTRL=0x02, PORT_GPO_BASE=0x10, PORT_BORDER=0xFE;
  - status bit-index constants.
- One natural sub-module: io_fifo. It is a synchronous FIFO, parametrised by width and depth, with push, pop, full, empty, count and head outputs. It is also reusable for a future serial port.

Test Plan:
- Reset then read 0x01 -> pin=0x00. Write 0xFE with out=0x05 -> border=3'b101, single commit even with port_we held 3 cycles.
- Push 0x1C, 0x32 via kdone:
  - read 0x01 -> 0x21;
  - read 0x00 -> 0x1C; after the port_rd fall, read 0x00 -> 0x32; then empty, reading 0x00.
- KBD_DEPTH=16, push 17 bytes:
  - read 0x01 -> 0xF7 (count saturated to 15, overflow, full, non-empty);
  - second read of 0x01 -> 0xF3 (overflow cleared).
- FIFO full, pop and kdone in the same cycle -> count stays 16, overflow stays 0, new byte is the last one out.
- NUM_OUT=4: write 0x13 with 0xA5 -> gpo[31:24]=0xA5, read 0x13 -> 0xA5. Write 0x14 -> ignored, read 0x14 -> 0x00.
- IO_HUB_TIMER_EN, TIMER_DIV=10, write 0x02 with 0x01, iff1=1:
  - tick pending set at cycle 10, irq high the next cycle;
  - write 0x02 with 0x03 -> pending cleared, irq low one cycle later.
